traceback_packet_writer: RTL and testbench
==========================================

TRACEBACK_PACKET_WRITER -- requirements
Module: traceback_packet_writer

Interface
REQ-001 SHALL have parameter SEQ_LENGTH, default 32: cells per row and per column.
REQ-002 SHALL have parameter ROW_BITS_WIDTH, default 5: row index width.
REQ-003 SHALL have parameter COL_BITS_WIDTH, default 5: column index width.
REQ-004 SHALL have parameter SCORE_WIDTH, default 8: unsigned cell score width.
REQ-005 SHALL have parameter DATA_PACKET_SIZE, default 4: matrix memory word width.
REQ-006 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port start_of_matrix, input, 1 bit: begin a new matrix and clear all tracking.
REQ-009 SHALL have port cell_valid, input, 1 bit: cell_dir and cell_score are valid.
REQ-010 SHALL have port cell_ready, output, 1 bit: the block accepts the cell this cycle.
REQ-011 SHALL have port cell_dir, input, 2 bits: DIAG=00, LEFT=01, TOP=10.
REQ-012 SHALL have port cell_score, input, SCORE_WIDTH bits: cell score.
REQ-013 SHALL have port mem_ready, input, 1 bit: matrix memory accepts the write.
REQ-014 SHALL have ports wr_en (1 bit), wr_row (ROW_BITS_WIDTH bits), wr_col (COL_BITS_WIDTH bits) and wr_packet (DATA_PACKET_SIZE bits), all outputs: the memory write request.
REQ-015 SHALL have ports max_row (ROW_BITS_WIDTH bits), max_col (COL_BITS_WIDTH bits) and max_score (SCORE_WIDTH bits), all outputs: the traceback start point.
REQ-016 SHALL have port matrix_done, output, 1 bit: one-cycle pulse when the matrix is fully written.
REQ-017 SHALL have port dir_err, output, 1 bit: sticky flag set when an illegal direction is received.

Function
REQ-018 SHALL implement states IDLE, FILL, FLUSH and DONE.
REQ-019 SHALL use these transitions:
- IDLE to FILL on start_of_matrix.
- FILL to FLUSH after accepting the cell at (SEQ_LENGTH-1, SEQ_LENGTH-1).
- FLUSH to DONE when no write is pending.
- DONE to IDLE after one cycle.
REQ-020 SHALL accept a cell when cell_valid && cell_ready, with cell_ready = (state==FILL) && (!wr_en || mem_ready).
REQ-021 SHALL take accepted cells in row-major order; the column counter wraps at SEQ_LENGTH-1 to 0 and increments the row counter.
REQ-022 SHALL register an accepted cell into the write stage the next cycle: wr_en=1, and wr_row/wr_col equal the cell's coordinates (1-cycle latency).
REQ-023 SHALL hold wr_en and all wr_* stable while wr_en && !mem_ready; a write completes on a wr_en && mem_ready cycle.
REQ-024 SHALL allow a new write to be loaded in the same cycle the previous one completes (full throughput).
REQ-025 SHALL pack wr_packet as follows:
- [1:0] = direction.
- [DATA_PACKET_SIZE-1] = stop bit = (cell_score==0).
- Remaining bits per REQ-035/036.
REQ-026 SHALL write cell_dir=11 as DIAG (00) and set dir_err.
REQ-027 SHALL update max_score/max_row/max_col on acceptance only when cell_score > max_score, so ties keep the earliest cell in row-major order.
REQ-028 SHALL treat start_of_matrix in any state as follows:
- Zero the counters, max_row, max_col, max_score and dir_err.
- Drop any pending write (wr_en=0 the next cycle).
- Enter FILL.
- Not accept a cell in that cycle.
REQ-029 SHALL assert matrix_done only during the DONE state; max_* remain valid until the next start_of_matrix.
REQ-030 SHALL ignore cell_valid outside FILL.

Reset
REQ-031 SHALL, on rst=1 at a clock edge, enter IDLE and zero wr_en, wr_row, wr_col, wr_packet, the counters, max_row, max_col, max_score, matrix_done and dir_err.
REQ-032 SHALL give rst priority over start_of_matrix.
REQ-033 SHALL, if rst is asserted mid-matrix, discard the pending write and all progress.
REQ-034 SHALL keep cell_ready=0 while in reset.

Configuration
REQ-035 SHALL, with macro TB_PACKET_PARITY_EN defined, set wr_packet[2] = XOR of wr_packet[1:0] and the stop bit (even parity).
REQ-036 SHALL, without TB_PACKET_PARITY_EN, tie wr_packet[2] to 0.

Verification
REQ-037 SHALL cover full matrix fill: start, then 1024 cells with mem_ready=1 -> 1024 writes in row-major order, matrix_done pulses 2 cycles after the last acceptance.
REQ-038 SHALL cover backpressure: mem_ready=0 for 3 cycles on write (0,5) -> wr_* stable, cell_ready=0, no cell lost or duplicated.
REQ-039 SHALL cover max tie: score 9 at (2,3), then score 9 at (4,1) -> max_row=2, max_col=3, max_score=9.
REQ-040 SHALL cover stop and illegal direction:
- Score 0 with dir=LEFT -> wr_packet=4'b1001.
- dir=11 -> wr_packet[1:0]=00 and dir_err=1.
- With TB_PACKET_PARITY_EN, dir=01 and score 5 -> wr_packet=4'b0101.
REQ-041 SHALL cover restart mid-matrix: start_of_matrix at cell (7,10) with a write pending -> wr_en=0 next cycle, the next accepted cell writes to (0,0), max_score=0 before it.
REQ-042 SHALL cover reset mid-FLUSH: rst=1 while wr_en=1 -> IDLE, all outputs zero, matrix_done never pulses.

Source files
------------

// File: rtl/traceback_packet_writer.sv
// Streams scored alignment cells into the traceback matrix memory and tracks the best-scoring cell.
// Optional build macro TB_PACKET_PARITY_EN puts even parity in wr_packet[2].
module traceback_packet_writer #(
   parameter int SEQ_LENGTH       = 32,
   parameter int ROW_BITS_WIDTH   = 5,
   parameter int COL_BITS_WIDTH   = 5,
   parameter int SCORE_WIDTH      = 8,
   parameter int DATA_PACKET_SIZE = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start_of_matrix,
   input  logic                        cell_valid,
   output logic                        cell_ready,
   input  logic [1:0]                  cell_dir,
   input  logic [SCORE_WIDTH-1:0]      cell_score,
   input  logic                        mem_ready,
   output logic                        wr_en,
   output logic [ROW_BITS_WIDTH-1:0]   wr_row,
   output logic [COL_BITS_WIDTH-1:0]   wr_col,
   output logic [DATA_PACKET_SIZE-1:0] wr_packet,
   output logic [ROW_BITS_WIDTH-1:0]   max_row,
   output logic [COL_BITS_WIDTH-1:0]   max_col,
   output logic [SCORE_WIDTH-1:0]      max_score,
   output logic                        matrix_done,
   output logic                        dir_err
);

   typedef enum logic [1:0] {IDLE, FILL, FLUSH, DONE} state_t;

   localparam logic [ROW_BITS_WIDTH-1:0] ROW_LAST = ROW_BITS_WIDTH'(SEQ_LENGTH - 1);
   localparam logic [COL_BITS_WIDTH-1:0] COL_LAST = COL_BITS_WIDTH'(SEQ_LENGTH - 1);

   state_t                        state;
   state_t                        state_next;
   logic [ROW_BITS_WIDTH-1:0]     row_cnt;
   logic [COL_BITS_WIDTH-1:0]     col_cnt;
   logic                          accept;
   logic                          last_cell;
   logic                          write_done;
   logic [1:0]                    dir_eff;
   logic                          stop_bit;
   logic [DATA_PACKET_SIZE-1:0]   packet;

   // A restart or reset cycle never takes a cell, even though the FILL rule alone would allow it.
   assign cell_ready = !rst && !start_of_matrix && (state == FILL) && (!wr_en || mem_ready);
   assign accept     = cell_valid && cell_ready;
   assign last_cell  = (row_cnt == ROW_LAST) && (col_cnt == COL_LAST);
   assign write_done = wr_en && mem_ready;

   always_comb begin
      dir_eff  = (cell_dir == 2'b11) ? 2'b00 : cell_dir;
      stop_bit = (cell_score == '0);
      packet   = '0;
      packet[1:0] = dir_eff;
`ifdef TB_PACKET_PARITY_EN
      packet[2] = ^{dir_eff, stop_bit};
`endif
      packet[DATA_PACKET_SIZE-1] = stop_bit;
   end

   always_comb begin
      state_next  = state;
      matrix_done = 1'b0;
      unique case (state)
         IDLE:  state_next = state;
         FILL:  if (accept && last_cell) state_next = FLUSH;
         FLUSH: if (!wr_en || mem_ready) state_next = DONE;
         DONE: begin
            matrix_done = 1'b1;
            state_next  = IDLE;
         end
      endcase
      if (start_of_matrix) state_next = FILL;
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Write stage, cell counters and running maximum share one register process.
   always_ff @(posedge clk) begin
      if (rst || start_of_matrix) begin
         wr_en     <= 1'b0;
         wr_row    <= '0;
         wr_col    <= '0;
         wr_packet <= '0;
         row_cnt   <= '0;
         col_cnt   <= '0;
         max_row   <= '0;
         max_col   <= '0;
         max_score <= '0;
         dir_err   <= 1'b0;
      end else if (accept) begin
         wr_en     <= 1'b1;
         wr_row    <= row_cnt;
         wr_col    <= col_cnt;
         wr_packet <= packet;
         if (col_cnt == COL_LAST) begin
            col_cnt <= '0;
            row_cnt <= (row_cnt == ROW_LAST) ? '0 : row_cnt + 1'b1;
         end else begin
            col_cnt <= col_cnt + 1'b1;
         end
         if (cell_score > max_score) begin
            max_score <= cell_score;
            max_row   <= row_cnt;
            max_col   <= col_cnt;
         end
         if (cell_dir == 2'b11) dir_err <= 1'b1;
      end else if (write_done) begin
         wr_en <= 1'b0;
      end
   end

endmodule

// File: tb/tb_traceback_packet_writer.sv
// Self-checking bench for traceback_packet_writer: directed steps plus random cells against a matrix-level model.
// Honours TB_PACKET_PARITY_EN in its packet expectation.
module tb_traceback_packet_writer;

   localparam int SEQ    = 32;
   localparam int NCELLS = SEQ * SEQ;

   logic       clk = 1'b0;
   logic       rst;
   logic       start_of_matrix;
   logic       cell_valid;
   logic       cell_ready;
   logic [1:0] cell_dir;
   logic [7:0] cell_score;
   logic       mem_ready;
   logic       wr_en;
   logic [4:0] wr_row;
   logic [4:0] wr_col;
   logic [3:0] wr_packet;
   logic [4:0] max_row;
   logic [4:0] max_col;
   logic [7:0] max_score;
   logic       matrix_done;
   logic       dir_err;

   int errors = 0;
   int checks = 0;

   // Reference model: number of cells taken, one pending write, best cell so far.
   int         m_count = 0;
   bit         m_fill = 0;
   bit         m_flush = 0;
   bit         m_pending = 0;
   bit         m_zero_wr = 0;
   int         m_wr_row = 0;
   int         m_wr_col = 0;
   logic [3:0] m_wr_pkt = '0;
   int         m_max_score = 0;
   int         m_max_row = 0;
   int         m_max_col = 0;
   bit         m_dir_err = 0;
   bit         m_done = 0;

   int cyc = 0;
   int last_acc_cyc = -1;
   int done_cyc = -1;
   int dut_done_pulses = 0;

   logic [1:0] d;
   logic [7:0] s;

   traceback_packet_writer dut (
      .clk             (clk),
      .rst             (rst),
      .start_of_matrix (start_of_matrix),
      .cell_valid      (cell_valid),
      .cell_ready      (cell_ready),
      .cell_dir        (cell_dir),
      .cell_score      (cell_score),
      .mem_ready       (mem_ready),
      .wr_en           (wr_en),
      .wr_row          (wr_row),
      .wr_col          (wr_col),
      .wr_packet       (wr_packet),
      .max_row         (max_row),
      .max_col         (max_col),
      .max_score       (max_score),
      .matrix_done     (matrix_done),
      .dir_err         (dir_err)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] expPacket(input logic [1:0] dir, input logic [7:0] score);
      logic [1:0] de;
      logic       stop;
      logic       par;
      de   = (dir == 2'b11) ? 2'b00 : dir;
      stop = (score == 8'd0);
      par  = 1'b0;
`ifdef TB_PACKET_PARITY_EN
      par = de[0] ^ de[1] ^ stop;
`endif
      return {stop, par, de};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput();
      if (matrix_done === 1'b1) begin
         dut_done_pulses++;
         if (done_cyc < 0) done_cyc = cyc + 1;
      end
      check("wr_en", wr_en, m_pending);
      if (m_pending || m_zero_wr) begin
         check("wr_row", wr_row, m_wr_row);
         check("wr_col", wr_col, m_wr_col);
         check("wr_packet", wr_packet, m_wr_pkt);
      end
      check("max_row", max_row, m_max_row);
      check("max_col", max_col, m_max_col);
      check("max_score", max_score, m_max_score);
      check("dir_err", dir_err, m_dir_err);
      check("matrix_done", matrix_done, m_done);
   endtask

   // One clock cycle: drive inputs, check readiness, advance the model at the edge, check outputs.
   task automatic applyStimulus(input logic r, input logic sof, input logic v,
                                input logic [1:0] dir, input logic [7:0] score, input logic mr);
      bit exp_ready;
      bit acc;
      bit done_next;
      cyc++;
      rst             = r;
      start_of_matrix = sof;
      cell_valid      = v;
      cell_dir        = dir;
      cell_score      = score;
      mem_ready       = mr;
      #1;
      exp_ready = !r && !sof && m_fill && (!m_pending || mr);
      check("cell_ready", cell_ready, exp_ready);
      @(posedge clk);
      if (r) begin
         m_count = 0; m_fill = 0; m_flush = 0; m_pending = 0; m_zero_wr = 1;
         m_wr_row = 0; m_wr_col = 0; m_wr_pkt = '0;
         m_max_score = 0; m_max_row = 0; m_max_col = 0; m_dir_err = 0; m_done = 0;
      end else if (sof) begin
         m_count = 0; m_fill = 1; m_flush = 0; m_pending = 0; m_zero_wr = 0;
         m_max_score = 0; m_max_row = 0; m_max_col = 0; m_dir_err = 0; m_done = 0;
      end else begin
         acc       = v && exp_ready;
         done_next = m_flush && (!m_pending || mr);
         if (acc) begin
            m_pending = 1;
            m_zero_wr = 0;
            m_wr_row  = m_count / SEQ;
            m_wr_col  = m_count % SEQ;
            m_wr_pkt  = expPacket(dir, score);
            if (int'(score) > m_max_score) begin
               m_max_score = int'(score);
               m_max_row   = m_wr_row;
               m_max_col   = m_wr_col;
            end
            if (dir == 2'b11) m_dir_err = 1;
            m_count++;
            last_acc_cyc = cyc;
            if (m_count == NCELLS) begin
               m_fill  = 0;
               m_flush = 1;
            end
         end else if (m_pending && mr) begin
            m_pending = 0;
         end
         if (done_next) m_flush = 0;
         m_done = done_next;
      end
      #1;
      checkOutput();
   endtask

   initial begin
      // Reset, then cells offered while idle must be ignored.
      applyStimulus(1, 0, 0, 2'b00, 8'd0, 0);
      applyStimulus(1, 1, 1, 2'b01, 8'd9, 1);
      repeat (3) applyStimulus(0, 0, 1, 2'b01, 8'd7, 1);

      // Matrix 1: full fill at full throughput with directed cells for stop, illegal dir, parity and max tie.
      done_cyc = -1;
      dut_done_pulses = 0;
      applyStimulus(0, 1, 0, 2'b00, 8'd0, 1);
      for (int i = 0; i < NCELLS + 50 && m_count < NCELLS; i++) begin
         d = 2'($urandom_range(0, 2));
         s = 8'($urandom_range(0, 8));
         case (m_count)
            5:       begin d = 2'b01; s = 8'd0; end
            6:       begin d = 2'b11; s = 8'd3; end
            7:       begin d = 2'b01; s = 8'd5; end
            67:      begin d = 2'b00; s = 8'd9; end
            129:     begin d = 2'b10; s = 8'd9; end
            default: ;
         endcase
         applyStimulus(0, 0, 1, d, s, 1);
      end
      repeat (4) applyStimulus(0, 0, 0, 2'b00, 8'd0, 1);
      check("m1_done_pulses", dut_done_pulses, 1);
      check("m1_done_latency", done_cyc - last_acc_cyc, 2);
      check("m1_tie_max_row", max_row, 2);
      check("m1_tie_max_col", max_col, 3);
      check("m1_tie_max_score", max_score, 9);
      check("m1_dir_err", dir_err, 1);

      // Matrix 2: backpressure on write (0,5), then random traffic up to cell (7,10).
      applyStimulus(0, 1, 0, 2'b00, 8'd0, 1);
      for (int i = 0; i < 6; i++)
         applyStimulus(0, 0, 1, 2'($urandom_range(0, 2)), 8'($urandom_range(1, 255)), 1);
      check("bp_first_col", wr_col, 5);
      repeat (3) applyStimulus(0, 0, 1, 2'($urandom_range(0, 3)), 8'($urandom), 0);
      check("bp_hold_col", wr_col, 5);
      check("bp_hold_en", wr_en, 1);
      for (int i = 0; i < 3000 && m_count < 7 * SEQ + 10; i++)
         applyStimulus(0, 0, ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                       8'($urandom), ($urandom_range(0, 3) != 0));
      check("restart_pending_before", wr_en, 1);
      applyStimulus(0, 1, 1, 2'b10, 8'd200, 1);
      check("restart_wr_en", wr_en, 0);
      check("restart_max_score", max_score, 0);
      applyStimulus(0, 0, 1, 2'b01, 8'd20, 1);
      check("restart_wr_row", wr_row, 0);
      check("restart_wr_col", wr_col, 0);
      check("restart_max_score_after", max_score, 20);

      // Remaining fill with random handshakes, then reset while the final write is stalled.
      dut_done_pulses = 0;
      for (int i = 0; i < 8000 && m_count < NCELLS; i++)
         applyStimulus(0, 0, ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                       8'($urandom), ($urandom_range(0, 3) != 0));
      applyStimulus(0, 0, 0, 2'b00, 8'd0, 0);
      check("flush_wr_en", wr_en, 1);
      applyStimulus(1, 1, 1, 2'b01, 8'd50, 0);
      check("rst_flush_wr_en", wr_en, 0);
      check("rst_flush_max_score", max_score, 0);
      repeat (3) applyStimulus(0, 0, 1, 2'b01, 8'd50, 1);
      check("m3_done_pulses", dut_done_pulses, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
